panel_input_encoder: RTL and testbench
======================================

Name: panel_input_encoder

Overview:
- Front-panel input stage for the register test datapath; drives its 12-bit io_bin command bus.
- Synchronises and debounces raw board switches and push-buttons.
- Converts each button press into a single-cycle one-hot write strobe on io_bin[6:4], qualified by stable 4-bit switch data on io_bin[3:0].
- Upper bits are reserved.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable sampled cycles required before a debounced bit changes; legal range 2..2^20; FPGA builds override with 500000.
- REPEAT_CYCLES, 16, auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined; legal range 2 or more.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; deasserts synchronously to clock externally.
- io_sw  input  4  raw slide switches, asynchronous to clock.
- io_btn  input  3  raw push-buttons, active-high, asynchronous to clock.
- io_bin  output  12  command bus: [3:0] data, [6:4] one-hot write strobe (bit 4 = btn0), [11:7] tied 0.
- io_conflict  output  1  one-cycle pulse when simultaneous presses caused a press to be dropped.

Behaviour:
- Reset (reset low, asynchronous):
  - All synchronisers, debounce counters, debounced bits and edge-detect flops go to 0.
  - FSM enters IDLE.
  - io_bin = 12'h000 and io_conflict = 0 immediately, with no clock needed.
- Synchroniser: each of the 7 raw inputs passes through 2 flops (sync1, sync2).
- Debounce (per bit):
  - Counter, width clog2(DEBOUNCE_CYCLES)+1.
  - If sync2 equals deb, the counter clears.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES, deb takes sync2 and the counter clears.
  - Any return to equality before that restarts the count. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: raw input changes before edge N and is held. deb changes at edge N+1+DEBOUNCE_CYCLES. The strobe is high in the cycle following edge N+2+DEBOUNCE_CYCLES.
- Edge detect: rise[i] = deb_btn[i] & ~deb_btn_d[i].
- FSM states: IDLE, FIRE, WAIT_RELEASE.
  - IDLE: if any rise bit is set, go to FIRE.
    - Register strobe = one-hot of the lowest-index rising button.
    - Capture deb_sw into the data register.
    - If more than one rise bit is set, pulse io_conflict in the same cycle as the strobe.
  - FIRE: lasts exactly 1 cycle with the strobe driven, then clear the strobe and go to WAIT_RELEASE.
  - WAIT_RELEASE: hold until all deb_btn == 0, then return to IDLE. Presses of other buttons during FIRE or WAIT_RELEASE are ignored (no strobe, no conflict).
- Data hold: in IDLE, io_bin[3:0] tracks deb_sw registered (1-cycle lag). In FIRE and WAIT_RELEASE it holds the captured value, so data is stable during the strobe.
- Strobe bits: never more than one strobe bit is high; never high for two consecutive cycles, except under auto-repeat.
- Reset mid-operation: the FSM aborts to IDLE and a strobe in flight is cleared.
- After reset: a button already held at reset produces exactly one strobe, after debounce, because deb_btn_d resets to 0.

Optional Feature:
- Macro: PANEL_INPUT_AUTO_REPEAT_EN.
- Defined:
  - WAIT_RELEASE runs a repeat counter.
  - While the originating button stays debounced-high for REPEAT_CYCLES cycles, re-enter FIRE with the same strobe bit and a re-captured deb_sw, then restart the counter.
  - Release of that button returns to IDLE once all buttons are low.
- Undefined: no repeat counter exists; exactly one strobe per press.

Decomposition:
- Shared package panel_pkg holds:
  - FSM state enum (IDLE, FIRE, WAIT_RELEASE);
  - io_bin field position constants (DATA_LSB=0, DATA_W=4, STB_LSB=4, NUM_BTN=3, BIN_W=12).
- One sub-module: panel_debounce. It covers a single bit: 2-flop synchroniser, counter, deb output. It is parameterised by DEBOUNCE_CYCLES and instantiated 7 times.

Test Plan:
- Reset then idle: assert reset low mid-cycle with no clock edge -> io_bin == 12'h000 and io_conflict == 0 at once.
- Clean press: io_sw=4'd5, btn0 high from before edge 0 and held 20 cycles (DEBOUNCE_CYCLES=4) -> io_bin == 12'h015 for exactly the cycle after edge 6, then 12'h005. Release, then press btn2 with io_sw=4'd15 -> one pulse io_bin == 12'h04F.
- Bounce rejection: btn1 toggled high 3 cycles, low 1, high 2, low -> no strobe ever; io_bin[6:4] stays 0.
- Data hold: press btn1 with io_sw=3, then change io_sw to 9 while the button is held -> strobe 12'h023, then io_bin[3:0] stays 3 until release. After release and IDLE, io_bin[3:0] becomes 9.
- Simultaneous press: btn0 and btn2 rise in the same cycle -> single strobe io_bin[4]; io_conflict pulses in the same cycle; no btn2 strobe until all are released and btn2 is pressed again.
- Reset mid-op: drive reset low during FIRE -> strobe drops immediately. With btn held through release of reset -> exactly one strobe, DEBOUNCE_CYCLES+3 cycles later. With PANEL_INPUT_AUTO_REPEAT_EN and REPEAT_CYCLES=16 -> strobes repeat every 16 cycles while held.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared types and io_bin field layout for the front-panel input encoder.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    WAIT_RELEASE
  } state_t;

  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 4;
  localparam int STB_LSB  = 4;
  localparam int NUM_BTN  = 3;
  localparam int BIN_W    = 12;

  function automatic logic [NUM_BTN-1:0] lowest_one_hot(input logic [NUM_BTN-1:0] v);
    return v & (~v + NUM_BTN'(1));
  endfunction

  function automatic logic multi_hot(input logic [NUM_BTN-1:0] v);
    return (v & (v - NUM_BTN'(1))) != '0;
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// One raw board input: two-flop synchroniser followed by a stable-count debouncer.
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // The edge that would take the count to DEBOUNCE_CYCLES commits the new level.
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/panel_input_encoder.sv
// Front-panel encoder: debounced switches/buttons to a one-hot write strobe on io_bin.
// Optional auto-repeat while a button is held: define PANEL_INPUT_AUTO_REPEAT_EN.
module panel_input_encoder
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  io_sw,
  input  logic [NUM_BTN-1:0] io_btn,
  output logic [BIN_W-1:0]   io_bin,
  output logic               io_conflict
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("panel_input_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  localparam int NUM_IN = DATA_W + NUM_BTN;

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  deb;
  logic [DATA_W-1:0]  deb_sw;
  logic [NUM_BTN-1:0] deb_btn;
  logic [NUM_BTN-1:0] deb_btn_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] first_rise;

  assign raw = {io_btn, io_sw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clock),
      .rst_n(reset),
      .raw  (raw[i]),
      .deb  (deb[i])
    );
  end

  assign deb_sw     = deb[DATA_W-1:0];
  assign deb_btn    = deb[NUM_IN-1:DATA_W];
  assign rise       = deb_btn & ~deb_btn_d;
  assign first_rise = lowest_one_hot(rise);

  state_t             state, state_next;
  logic [NUM_BTN-1:0] strobe, strobe_next;
  logic [DATA_W-1:0]  data, data_next;
  logic               conflict, conflict_next;

`ifdef PANEL_INPUT_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
  // WAIT_RELEASE entered one cycle after the strobe, so the repeat fires two counts early.
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 2);

  logic [NUM_BTN-1:0] origin, origin_next;
  logic [REP_W-1:0]   rep_cnt, rep_next;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      strobe    <= '0;
      data      <= '0;
      conflict  <= 1'b0;
      deb_btn_d <= '0;
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
      origin    <= '0;
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_next;
      strobe    <= strobe_next;
      data      <= data_next;
      conflict  <= conflict_next;
      deb_btn_d <= deb_btn;
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
      origin    <= origin_next;
      rep_cnt   <= rep_next;
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    strobe_next   = '0;
    data_next     = data;
    conflict_next = 1'b0;
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
    origin_next   = origin;
    rep_next      = rep_cnt;
`endif
    unique case (state)
      IDLE: begin
        data_next = deb_sw;
        if (rise != '0) begin
          state_next    = FIRE;
          strobe_next   = first_rise;
          conflict_next = multi_hot(rise);
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
          origin_next   = first_rise;
`endif
        end
      end
      FIRE: begin
        state_next = WAIT_RELEASE;
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
        rep_next   = '0;
`endif
      end
      WAIT_RELEASE: begin
        if (deb_btn == '0) begin
          state_next = IDLE;
        end
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
        else if ((deb_btn & origin) != '0) begin
          if (rep_cnt == REP_LAST) begin
            state_next  = FIRE;
            strobe_next = origin;
            data_next   = deb_sw;
          end else begin
            rep_next = rep_cnt + REP_W'(1);
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io_bin                        = '0;
    io_bin[DATA_LSB +: DATA_W]    = data;
    io_bin[STB_LSB  +: NUM_BTN]   = strobe;
  end

  assign io_conflict = conflict;

endmodule

// File: tb/tb_panel_input_encoder.sv
// Scoreboard bench for panel_input_encoder: expected strobe cycles are queued at stimulus time.
module tb_panel_input_encoder;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  io_sw = '0;
  logic [2:0]  io_btn = '0;
  logic [11:0] io_bin;
  logic        io_conflict;

  typedef struct {
    int          at;
    logic [11:0] bin;
    logic        conf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  panel_input_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .io_sw      (io_sw),
    .io_btn     (io_btn),
    .io_bin     (io_bin),
    .io_conflict(io_conflict)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Every cycle: either the queued strobe is due, or no strobe/conflict may appear.
  always @(negedge clock) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        vectors++;
        errors++;
        $display("FAIL missed_strobe: nothing compared at cycle %0d, expected io_bin=%h", exp_q[0].at, exp_q[0].bin);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        mon_e = exp_q.pop_front();
        vectors++;
        if (io_bin !== mon_e.bin || io_conflict !== mon_e.conf) begin
          errors++;
          $display("FAIL strobe_cycle_%0d: io_bin=%h conflict=%b, expected io_bin=%h conflict=%b",
                   cyc, io_bin, io_conflict, mon_e.bin, mon_e.conf);
        end
      end else begin
        vectors++;
        if (io_bin[11:4] !== 8'h00 || io_conflict !== 1'b0) begin
          errors++;
          $display("FAIL idle_cycle_%0d: io_bin=%h conflict=%b, expected no strobe and no conflict",
                   cyc, io_bin, io_conflict);
        end
      end
    end
  end

  task automatic push_exp(input int at, input logic [11:0] bin, input logic conf);
    exp_q.push_back('{at, bin, conf});
  endtask

  // s: first strobe cycle; r: negedge cycle at which the button is released.
  task automatic push_repeats(input int s, input int r, input logic [11:0] bin);
`ifdef PANEL_INPUT_AUTO_REPEAT_EN
    for (int j = 1; s + REP * j <= r + 2 + DEB; j++) push_exp(s + REP * j, bin, 1'b0);
`endif
  endtask

  task automatic press_hold(input logic [2:0] btn, input logic [3:0] sw, input int hold,
                            input logic [11:0] bin, input logic conf);
    int k;
    int s;
    @(negedge clock);
    io_sw  = sw;
    io_btn = btn;
    k = cyc;
    s = k + 3 + DEB;
    push_exp(s, bin, conf);
    push_repeats(s, k + hold, bin);
    for (int c = 1; c <= hold; c++) begin
      @(negedge clock);
      if (cyc == s + 1) begin
        #1;
        vectors++;
        if (io_bin !== {8'h00, bin[3:0]}) begin
          errors++;
          $display("FAIL after_strobe: io_bin=%h, expected %h", io_bin, {8'h00, bin[3:0]});
        end
      end
    end
    io_btn = '0;
    repeat (DEB + 8) @(negedge clock);
  endtask

  task automatic test_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (io_bin !== 12'h000 || io_conflict !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: io_bin=%h conflict=%b, expected 000/0", io_bin, io_conflict);
    end
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    vectors++;
    if (io_bin !== 12'h000) begin
      errors++;
      $display("FAIL idle_after_reset: io_bin=%h, expected 000", io_bin);
    end
  endtask

  task automatic test_clean_press();
    press_hold(3'b001, 4'd5, 20, 12'h015, 1'b0);
    press_hold(3'b100, 4'd15, 10, 12'h04F, 1'b0);
  endtask

  task automatic test_bounce();
    @(negedge clock);
    io_btn = 3'b010;
    repeat (3) @(negedge clock);
    io_btn = 3'b000;
    @(negedge clock);
    io_btn = 3'b010;
    repeat (2) @(negedge clock);
    io_btn = 3'b000;
    repeat (DEB + 8) @(negedge clock);
    #1;
    vectors++;
    if (io_bin[6:4] !== 3'b000) begin
      errors++;
      $display("FAIL bounce_strobe: io_bin[6:4]=%b, expected 000", io_bin[6:4]);
    end
  endtask

  task automatic test_data_hold();
    int k;
    @(negedge clock);
    io_sw  = 4'd3;
    io_btn = 3'b010;
    k = cyc;
    push_exp(k + 3 + DEB, 12'h023, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (c == 8)  io_sw  = 4'd9;
      if (c == 14) io_btn = 3'b000;
      if (c >= 8 && c <= 21) begin
        #1;
        vectors++;
        if (io_bin[3:0] !== 4'd3) begin
          errors++;
          $display("FAIL data_hold_c%0d: io_bin[3:0]=%0d, expected 3", c, io_bin[3:0]);
        end
      end
      if (c == 26) begin
        #1;
        vectors++;
        if (io_bin[3:0] !== 4'd9) begin
          errors++;
          $display("FAIL data_track: io_bin[3:0]=%0d, expected 9", io_bin[3:0]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int k;
    @(negedge clock);
    io_sw  = 4'd6;
    io_btn = 3'b101;
    k = cyc;
    push_exp(k + 3 + DEB, 12'h016, 1'b1);
    repeat (8) @(negedge clock);
    io_btn = 3'b100;
    repeat (4) @(negedge clock);
    io_btn = 3'b110;
    repeat (12) @(negedge clock);
    io_btn = 3'b000;
    repeat (DEB + 8) @(negedge clock);
    press_hold(3'b100, 4'd6, 10, 12'h046, 1'b0);
  endtask

  task automatic test_reset_midop();
    int k;
    int r;
    @(negedge clock);
    io_sw  = 4'd10;
    io_btn = 3'b001;
    k = cyc;
    push_exp(k + 3 + DEB, 12'h01A, 1'b0);
    while (cyc < k + 3 + DEB) @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (io_bin !== 12'h000 || io_conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_fire: io_bin=%h conflict=%b, expected 000/0", io_bin, io_conflict);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    r = cyc;
    push_exp(r + 3 + DEB, 12'h01A, 1'b0);
    push_repeats(r + 3 + DEB, r + 40, 12'h01A);
    repeat (40) @(negedge clock);
    io_btn = 3'b000;
    repeat (DEB + 8) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_data_hold();
    test_simultaneous();
    test_reset_midop();
    repeat (4) @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes: %0d expected strobes never compared, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
